// File: rtl/updown_sweep_ctrl.sv
// Sequencer for a shared loadable up/down counter: emits lo -> hi -> lo triangle
// sweeps a programmable number of times and holds the counter otherwise.
module updown_sweep_ctrl #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned SWEEP_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [WIDTH-1:0]   lo,
    input  logic [WIDTH-1:0]   hi,
    input  logic [SWEEP_W-1:0] sweeps,
    input  logic [WIDTH-1:0]   cnt_value,
    output logic               cnt_ld,
    output logic               cnt_ud,
    output logic [WIDTH-1:0]   cnt_data,
    output logic               busy,
    output logic               dir,
    output logic [SWEEP_W-1:0] sweep_idx,
    output logic               done,
    output logic               err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_UP,
        S_DOWN
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [WIDTH-1:0]     r_lo;
    logic [WIDTH-1:0]     r_hi;
    logic [SWEEP_W-1:0]   r_sweeps;
    logic [SWEEP_W-1:0]   r_sweep_idx;
    logic [SWEEP_W-1:0]   w_idx_inc;
    logic                 r_dir;
    logic                 r_done;
    logic                 r_err;
    logic                 w_accept;
    logic                 w_reject;
    logic                 w_sweep_end;
    logic                 w_finish;

    assign busy      = (r_state != S_IDLE);
    assign dir       = r_dir;
    assign sweep_idx = r_sweep_idx;
    assign done      = r_done;
    assign err       = r_err;
    assign w_idx_inc = r_sweep_idx + 1'b1;

    // The counter has no enable: every cycle that is not counting reloads cnt_value.
    always_comb begin
        w_next      = r_state;
        cnt_ld      = 1'b1;
        cnt_ud      = 1'b0;
        cnt_data    = cnt_value;
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        w_sweep_end = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if ((lo < hi) && (sweeps != '0)) begin
                        w_accept = 1'b1;
                        w_next   = S_LOAD;
                    end else begin
                        w_reject = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (abort) begin
                    w_next = S_IDLE;
                end else begin
                    cnt_data = r_lo;
                    w_next   = S_UP;
                end
            end
            S_UP: begin
                if (abort) begin
                    w_next = S_IDLE;
                end else begin
                    cnt_ld = 1'b0;
                    if (cnt_value != r_hi) begin
                        cnt_ud = 1'b1;
                    end else begin
                        w_next = S_DOWN;
                    end
                end
            end
            S_DOWN: begin
                if (abort) begin
                    w_next = S_IDLE;
                end else begin
                    cnt_ld = 1'b0;
                    if (cnt_value == r_lo) begin
                        w_sweep_end = 1'b1;
                        if (w_idx_inc == r_sweeps) begin
                            cnt_ld   = 1'b1;
                            cnt_data = r_lo;
                            w_finish = 1'b1;
                            w_next   = S_IDLE;
                        end else begin
                            cnt_ud = 1'b1;
                            w_next = S_UP;
                        end
                    end
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_lo        <= '0;
            r_hi        <= '0;
            r_sweeps    <= '0;
            r_sweep_idx <= '0;
            r_dir       <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_next;
            r_dir   <= (w_next == S_UP);
            r_done  <= w_finish;
            r_err   <= w_reject;
            if (w_accept) begin
                r_lo        <= lo;
                r_hi        <= hi;
                r_sweeps    <= sweeps;
                r_sweep_idx <= '0;
            end else if (w_sweep_end) begin
                r_sweep_idx <= w_idx_inc;
            end
        end
    end

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Bench for updown_sweep_ctrl: drives a behavioural counter and compares every cycle
// against a triangle-wave model indexed by cycles elapsed since the accepted start.
module tb_updown_sweep_ctrl;
    localparam int W  = 4;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [W-1:0]  lo = '0;
    logic [W-1:0]  hi = '0;
    logic [SW-1:0] sweeps = '0;
    logic [W-1:0]  cnt_value = '0;
    logic          cnt_ld, cnt_ud, busy, dir, done, err;
    logic [W-1:0]  cnt_data;
    logic [SW-1:0] sweep_idx;

    int errors = 0;
    int checks = 0;

    updown_sweep_ctrl #(.WIDTH(W), .SWEEP_W(SW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .lo(lo), .hi(hi), .sweeps(sweeps), .cnt_value(cnt_value),
        .cnt_ld(cnt_ld), .cnt_ud(cnt_ud), .cnt_data(cnt_data),
        .busy(busy), .dir(dir), .sweep_idx(sweep_idx), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // The shared counter: loadable up/down, no reset of its own.
    always @(posedge clk)
        cnt_value <= cnt_ld ? cnt_data : (cnt_ud ? cnt_value + 4'd1 : cnt_value - 4'd1);

    task automatic chk(input string nm, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
        end
    endtask

    // Counter value k edges after it was loaded with lo, on a triangle of period 2*(hi-lo).
    function automatic int tri_val(int l, int h, int k);
        int d;
        int p;
        d = h - l;
        p = k % (2 * d);
        return (p <= d) ? l + p : l + 2 * d - p;
    endfunction

    function automatic int exp_idx(int t, int per);
        return (t <= 1) ? 0 : (t - 2) / per;
    endfunction

    function automatic int exp_dir(int t, int per);
        int q;
        if (t < 1) return 0;
        q = (t - 1) % per;
        return ((q <= per / 2) && !(q == 0 && t > 1)) ? 1 : 0;
    endfunction

    // Model: m_t counts edges since the accepted start edge; the run occupies t = 0..1+P*S.
    bit m_run = 1'b0;
    bit m_done = 1'b0;
    bit m_err = 1'b0;
    int m_t = 0, m_lo = 0, m_hi = 0, m_s = 0, m_idx = 0, m_cnt = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_run  <= 1'b0;
            m_t    <= 0;
            m_idx  <= 0;
            m_done <= 1'b0;
            m_err  <= 1'b0;
        end else begin
            m_done <= 1'b0;
            m_err  <= 1'b0;
            if (m_run) begin
                if (abort) begin
                    m_run <= 1'b0;
                    m_idx <= exp_idx(m_t, 2 * (m_hi - m_lo));
                end else if (m_t == 1 + 2 * (m_hi - m_lo) * m_s) begin
                    m_run  <= 1'b0;
                    m_done <= 1'b1;
                    m_idx  <= m_s;
                end else begin
                    m_t   <= m_t + 1;
                    m_cnt <= tri_val(m_lo, m_hi, m_t);
                end
            end else if (start) begin
                if (int'(lo) < int'(hi) && sweeps != 0) begin
                    m_run <= 1'b1;
                    m_t   <= 0;
                    m_lo  <= int'(lo);
                    m_hi  <= int'(hi);
                    m_s   <= int'(sweeps);
                    m_idx <= 0;
                end else begin
                    m_err <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin : cmp
        int per;
        int fin;
        per = 2 * (m_hi - m_lo);
        fin = 1 + per * m_s;
        chk("count", cnt_value, m_cnt);
        chk("busy", busy, m_run);
        chk("done", done, m_done);
        chk("err", err, m_err);
        if (m_run) begin
            chk("sweep_idx", sweep_idx, exp_idx(m_t, per));
            chk("dir", dir, exp_dir(m_t, per));
        end else begin
            chk("sweep_idx", sweep_idx, m_idx);
            chk("dir", dir, 0);
        end
        if (!m_run || abort) begin
            chk("hold_ld", cnt_ld, 1);
            chk("hold_data", cnt_data, m_cnt);
        end else if (m_t == 0 || m_t == fin) begin
            chk("load_ld", cnt_ld, 1);
            chk("load_data", cnt_data, m_lo);
        end else begin
            chk("run_ld", cnt_ld, 0);
            chk("run_ud", cnt_ud, (tri_val(m_lo, m_hi, m_t) > m_cnt) ? 1 : 0);
        end
    end

    task automatic pulse_start(input int l, input int h, input int s);
        @(posedge clk);
        #2 lo = W'(l); hi = W'(h); sweeps = SW'(s); start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
    endtask

    int exp1[8] = '{2, 3, 4, 5, 4, 3, 2, 2};
    int got[8];
    int dn[8];
    int n;
    bit found;

    initial begin
        #1 rst = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #2 start = 1'($urandom); abort = 1'($urandom); lo = W'($urandom); hi = W'($urandom);
            sweeps = SW'($urandom);
            #1 chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_err", err, 0);
            chk("rst_idx", sweep_idx, 0);
            chk("rst_dir", dir, 0);
            chk("rst_ld", cnt_ld, 1);
        end
        start = 1'b0; abort = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;

        // single sweep 2..5..2
        pulse_start(2, 5, 1);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #3 got[i] = int'(cnt_value); dn[i] = int'(done);
        end
        for (int i = 0; i < 8; i++) chk("single_seq", got[i], exp1[i]);
        chk("single_done_E7", dn[6], 0);
        chk("single_done_E8", dn[7], 1);
        chk("single_idx", sweep_idx, 1);
        @(posedge clk);
        #3 chk("single_done_pulse", done, 0);

        // two full-range sweeps; mid-run input changes must be ignored
        pulse_start(0, 15, 2);
        n = 0;
        do begin
            @(posedge clk);
            #3 n++;
            if (n == 3) begin lo = 4'd9; hi = 4'd3; sweeps = '0; end
        end while (!done && n < 200);
        chk("multi_cycles", n, 62);
        chk("multi_idx", sweep_idx, 2);
        chk("multi_end_count", cnt_value, 0);

        // rejected starts
        pulse_start(7, 7, 1);
        #1 chk("rej_eq_err", err, 1);
        chk("rej_eq_busy", busy, 0);
        @(posedge clk);
        #3 chk("rej_err_pulse", err, 0);
        pulse_start(1, 3, 0);
        #1 chk("rej_zero_err", err, 1);
        chk("rej_zero_busy", busy, 0);
        chk("rej_hold", cnt_value, 0);

        // abort while counting up at 6
        pulse_start(1, 9, 3);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk);
            #3 found = (cnt_value == 4'd6) && dir;
        end
        chk("abort_reach", found, 1);
        abort = 1'b1;
        @(posedge clk);
        #2 abort = 1'b0;
        #1 chk("abort_busy", busy, 0);
        chk("abort_count", cnt_value, 6);
        chk("abort_idx", sweep_idx, 0);
        repeat (3) @(posedge clk);
        #3 chk("abort_hold", cnt_value, 6);
        chk("abort_nodone", done, 0);

        // start while busy, then async reset while counting down
        pulse_start(3, 10, 2);
        repeat (4) @(posedge clk);
        #2 start = 1'b1; lo = 4'd0; hi = 4'd1;
        @(posedge clk);
        #2 start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk);
            #3 found = busy && !dir;
        end
        chk("down_reach", found, 1);
        rst = 1'b0;
        #1 chk("midrst_busy", busy, 0);
        chk("midrst_idx", sweep_idx, 0);
        chk("midrst_dir", dir, 0);
        @(posedge clk);
        #2 rst = 1'b1;
        pulse_start(4, 6, 1);
        n = 0;
        do begin
            @(posedge clk);
            #3 n++;
        end while (!done && n < 50);
        chk("post_rst_cycles", n, 6);
        chk("post_rst_idx", sweep_idx, 1);

        // randomized traffic
        repeat (2500) begin
            @(posedge clk);
            #2 start = ($urandom % 6 == 0);
            abort = ($urandom % 45 == 0);
            lo = W'($urandom);
            hi = W'($urandom);
            sweeps = SW'($urandom % 3);
            rst = ($urandom % 400 != 0);
        end
        @(posedge clk);
        #2 start = 1'b0; abort = 1'b0; rst = 1'b1;
        repeat (3) @(posedge clk);
        #4 $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
